demux_8_hs: RTL and testbench

- Registered 1-to-8 demultiplexer, the write-side counterpart of the codebase's 8:1 selection muxes.
- Routes one N-bit input word to one of eight output lanes, or to all eight lanes in broadcast mode.
- Each lane holds a one-entry buffer with valid/ready handshakes on both sides.
- Used to distribute results (e.g. writeback or bus responses) to multiple consumers that each apply their own back-pressure.

---
 rtl/demux_8_hs.sv | 92 +++++++++
 tb/tb_demux_8_hs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_8_hs.sv
`default_nettype none
// ============================================================================
// Module   : demux_8_hs
// Purpose  : Registered 1-to-8 demultiplexer with valid/ready handshakes.
//            Each output lane has a one-entry buffer. A word goes to the
//            lane picked by in_sel, or to all eight lanes when in_bcast=1.
//            A broadcast is taken only when every lane can accept it.
// Revision : 1.0 - initial release
// ============================================================================
module demux_8_hs #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [2:0]     in_sel,
  input  logic           in_bcast,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready,
  output logic [8*N-1:0] out_data,
  output logic [CW-1:0]  xfer_count
);

  localparam int c_LANES = 8;

  logic          r_full [c_LANES];
  logic [N-1:0]  r_data [c_LANES];
  logic [CW-1:0] r_xfer_count;

  logic [7:0]    w_lane_can;
  logic [7:0]    w_write;
  logic [7:0]    w_drain;
  logic          w_accept;

  // A lane can take a word if it is empty or its word leaves this cycle.
  // A broadcast needs every lane; a directed write needs only its own lane.
  // in_sel is 3 bits wide, so every value indexes a real lane.
  always_comb begin
    in_ready = w_lane_can[in_sel];
    if (in_bcast) begin
      in_ready = &w_lane_can;
    end
  end

  assign w_accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < c_LANES; gi++) begin : g_lane
      assign w_lane_can[gi] = ~r_full[gi] | out_ready[gi];
      assign w_write[gi]    = w_accept & (in_bcast | (in_sel == 3'(gi)));
      assign w_drain[gi]    = r_full[gi] & out_ready[gi];

      // Lane buffer: a write wins over a drain, which gives bubble-free
      // pass-through when the consumer takes the old word in the same cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_full[gi] <= 1'b0;
          r_data[gi] <= '0;
        end else if (w_write[gi]) begin
          r_full[gi] <= 1'b1;
          r_data[gi] <= in_data;
        end else if (w_drain[gi]) begin
          r_full[gi] <= 1'b0;
        end
      end

      assign out_valid[gi]         = r_full[gi];
      assign out_data[gi*N +: N]   = r_data[gi];
    end
  endgenerate

  // Count accepted input transfers; a broadcast counts once. Wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (w_accept) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;

  // Lane write/drain vectors are kept whole for readability of waveforms.
  logic w_unused;
  assign w_unused = ^{w_write, w_drain};

endmodule
`default_nettype wire

// File: tb/tb_demux_8_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_8_hs
// Purpose  : Self-checking bench for demux_8_hs with a behavioural lane model.
//            A second instance with a 4-bit counter exercises wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_8_hs;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [N-1:0]   in_data;
  logic [2:0]     in_sel;
  logic           in_bcast;
  logic [7:0]     out_ready;

  wire            in_ready,  in_ready4;
  wire  [7:0]     out_valid, out_valid4;
  wire  [8*N-1:0] out_data,  out_data4;
  wire  [15:0]    xfer_count;
  wire  [3:0]     xfer_count4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic          m_full [8];
  logic [N-1:0]  m_data [8];
  int unsigned   m_count;

  demux_8_hs #(.N(N), .CW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  demux_8_hs #(.N(N), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .xfer_count(xfer_count4)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic m_ready();
    logic ok;
    if (in_bcast) begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++) ok = ok & (!m_full[i] || out_ready[i]);
    end else begin
      ok = !m_full[in_sel] || out_ready[in_sel];
    end
    return ok;
  endfunction

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [8*N-1:0] m_out();
    logic [8*N-1:0] d;
    for (int i = 0; i < 8; i++) d[i*N +: N] = m_data[i];
    return d;
  endfunction

  task automatic model_step();
    logic acc;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = '0;
      end
      m_count = 0;
    end else begin
      acc = in_valid && m_ready();
      for (int i = 0; i < 8; i++) begin
        if (acc && (in_bcast || in_sel == 3'(i))) begin
          m_full[i] = 1'b1;
          m_data[i] = in_data;
        end else if (m_full[i] && out_ready[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (acc) m_count = m_count + 1;
    end
  endtask

  // One clock: update the model at the edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0;
    in_bcast = 1'b0; out_ready = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (xfer_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_write();
    in_data = 32'hDEADBEEF; in_sel = 3'd5; in_valid = 1'b1; out_ready = '0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 8'b0010_0000) begin errors++; $display("FAIL single_valid got=%b exp=00100000", out_valid); end
    checks++; if (out_data[5*N +: N] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", out_data[5*N +: N]); end
    checks++; if (xfer_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_full got=%b exp=0", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = '0; in_sel = 3'd2; in_bcast = 1'b0;
    in_data = 32'h11111111; in_valid = 1'b1;
    tick();
    in_data = 32'h12345678;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_data[2*N +: N] !== 32'h11111111 || out_valid[2] !== 1'b1) begin
      errors++; $display("FAIL bp_hold got=%h/%b exp=11111111/1", out_data[2*N +: N], out_valid[2]); end
    out_ready = 8'b0000_0100;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = '0;
    #1;
    checks++; if (out_valid[2] !== 1'b1 || out_data[2*N +: N] !== 32'h12345678) begin
      errors++; $display("FAIL pass_data got=%h/%b exp=12345678/1", out_data[2*N +: N], out_valid[2]); end
  endtask

  task automatic test_streaming();
    int unsigned start;
    in_valid = 1'b0; out_ready = 8'hFF;
    tick();
    start = m_count;
    in_sel = 3'd0; in_bcast = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_data = 32'(k); in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
      checks++; if (out_valid[0] !== 1'b1 || out_data[N-1:0] !== 32'(k)) begin
        errors++; $display("FAIL stream_out k=%0d got=%h/%b exp=%h/1", k, out_data[N-1:0], out_valid[0], k); end
    end
    in_valid = 1'b0;
    #1;
    checks++; if (xfer_count !== 16'(start + 10)) begin
      errors++; $display("FAIL stream_count got=%0d exp=%0d", xfer_count, start + 10); end
  endtask

  task automatic test_broadcast();
    int unsigned start;
    logic [7:0] v_before;
    in_valid = 1'b0; out_ready = 8'hFF;
    tick();
    out_ready = '0; in_sel = 3'd7; in_bcast = 1'b0; in_data = 32'h77777777; in_valid = 1'b1;
    tick();
    start = m_count;
    v_before = m_valid();
    in_bcast = 1'b1; in_sel = 3'd0; in_data = 32'hA5A5A5A5;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_blocked_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== v_before || out_data[7*N +: N] !== 32'h77777777 || xfer_count !== 16'(start)) begin
      errors++; $display("FAIL bcast_blocked_state got=%b/%h/%0d exp=%b/77777777/%0d",
                        out_valid, out_data[7*N +: N], xfer_count, v_before, start); end
    out_ready = 8'h80;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
    #1;
    checks++; if (out_valid !== 8'hFF || out_data !== {8{32'hA5A5A5A5}}) begin
      errors++; $display("FAIL bcast_data got=%b/%h exp=ff/a5..", out_valid, out_data); end
    checks++; if (xfer_count !== 16'(start + 1)) begin
      errors++; $display("FAIL bcast_count got=%0d exp=%0d", xfer_count, start + 1); end
  endtask

  task automatic test_wrap();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0; out_ready = 8'hFF; in_bcast = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_sel = 3'($urandom_range(0, 7)); in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (xfer_count4 !== 4'd1) begin errors++; $display("FAIL wrap_count4 got=%0d exp=1", xfer_count4); end
    checks++; if (xfer_count !== 16'd17) begin errors++; $display("FAIL wrap_count16 got=%0d exp=17", xfer_count); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] lanes [3];
    lanes[0] = 3'd1; lanes[1] = 3'd3; lanes[2] = 3'd6;
    in_valid = 1'b0; out_ready = 8'hFF;
    tick();
    out_ready = '0; in_bcast = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_sel = lanes[k]; in_data = 32'hC0DE0000 + 32'(k);
      tick();
    end
    #1;
    checks++; if (out_valid !== 8'b0100_1010) begin errors++; $display("FAIL mid_fill got=%b exp=01001010", out_valid); end
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd0; in_data = 32'hFFFFFFFF;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 8'h00 || out_data !== '0 || xfer_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset got=%b/%h/%0d exp=00/0/0", out_valid, out_data, xfer_count); end
    tick();
    checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL mid_no_accept got=%b exp=00", out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) < 2);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_bcast  = ($urandom_range(0, 99) < 15);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 8'($urandom) & 8'($urandom);
      #1;
      if (!reset) begin
        checks++; if (in_ready !== m_ready()) begin
          errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      end
      tick();
      checks++; if (out_valid !== m_valid() || out_valid4 !== m_valid()) begin
        errors++; $display("FAIL rand_valid c=%0d got=%b/%b exp=%b", c, out_valid, out_valid4, m_valid()); end
      checks++; if (out_data !== m_out() || out_data4 !== m_out()) begin
        errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, m_out()); end
      checks++; if (xfer_count !== 16'(m_count) || xfer_count4 !== 4'(m_count)) begin
        errors++; $display("FAIL rand_count c=%0d got=%0d/%0d exp=%0d", c, xfer_count, xfer_count4, m_count); end
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
    m_count = 0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_streaming();
    test_broadcast();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
